// File: rtl/line_printer.sv
// Line printer: queues (lhs, rhs, last) character pairs and prints them over an 8N1 UART,
// appending CR/LF after the final pair of each line.
module line_printer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_lhs,
    input  logic [7:0] in_rhs,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       line_done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_CNT_W = 16;

    typedef struct packed {
        logic [7:0] lhs;
        logic [7:0] rhs;
        logic       last;
    } pair_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    pair_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_d;
    logic                 push, pop;

    state_t               state, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic [1:0]           byte_sel, byte_sel_d;
    pair_t                hold, hold_d;
    logic                 tx_d, line_done_d;
    logic                 last_tick;
    logic [1:0]           last_sel;
    logic [7:0]           cur_byte;

    // Byte sequence of one entry: lhs, rhs, then CR/LF for the last pair of a line
    function automatic logic [7:0] byte_of(input pair_t p, input logic [1:0] sel);
        case (sel)
            2'd0:    byte_of = p.lhs;
            2'd1:    byte_of = p.rhs;
            2'd2:    byte_of = 8'h0D;
            default: byte_of = 8'h0A;
        endcase
    endfunction

    assign in_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign busy     = (state != IDLE) || (count != '0);
    assign push     = in_valid && in_ready;

    // Next-state and serializer datapath
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        bit_idx_d   = bit_idx;
        byte_sel_d  = byte_sel;
        hold_d      = hold;
        line_done_d = 1'b0;
        pop         = 1'b0;
        last_tick   = (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
        last_sel    = hold.last ? 2'd3 : 2'd1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    hold_d     = mem[rd_ptr];
                    state_d    = START;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_sel_d = '0;
                end
            end
            START: begin
                if (last_tick) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    bit_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    bit_cnt_d = '0;
                    if (byte_sel == last_sel) begin
                        state_d     = IDLE;
                        line_done_d = hold.last;
                    end else begin
                        byte_sel_d = byte_sel + 2'd1;
                        state_d    = START;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cur_byte = byte_of(hold_d, byte_sel_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase

        count_d = count + CNT_W'(push) - CNT_W'(pop);
    end

    // State, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            byte_sel  <= '0;
            hold      <= '0;
            tx        <= 1'b1;
            line_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            bit_idx   <= bit_idx_d;
            byte_sel  <= byte_sel_d;
            hold      <= hold_d;
            tx        <= tx_d;
            line_done <= line_done_d;
            count     <= count_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{lhs: in_lhs, rhs: in_rhs, last: in_last};
    end

endmodule

// File: doc/line_printer.md
LINE_PRINTER -- requirements
Module: line_printer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of character-pair entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, character pair present on in_lhs/in_rhs/in_last.
REQ-006 SHALL have port in_lhs, input, 8, ASCII input-side character.
REQ-007 SHALL have port in_rhs, input, 8, ASCII transformed character.
REQ-008 SHALL have port in_last, input, 1, pair is the final pair of a line.
REQ-009 SHALL have port in_ready, output, 1, FIFO can accept a pair this cycle.
REQ-010 SHALL have port tx, output, 1, UART serial output, idle high.
REQ-011 SHALL have port busy, output, 1, serializer active or FIFO non-empty.
REQ-012 SHALL have port line_done, output, 1, one-cycle pulse when a line's LF stop bit completes.

Function
REQ-013 SHALL accept a pair into the FIFO on any rising edge where in_valid && in_ready; in_valid while in_ready low is ignored, no side effects.
REQ-014 SHALL drive in_ready = !rst && (FIFO count < FIFO_DEPTH); a pop in the same cycle does not raise in_ready while full.
REQ-015 SHALL preserve strict arrival order; no entry dropped or duplicated.
REQ-016 SHALL implement serializer states IDLE, START, DATA, STOP.
REQ-017 SHALL, in IDLE with FIFO non-empty, pop the head entry into a holding register and enter START on that same edge.
REQ-018 SHALL transmit per entry: in_lhs, then in_rhs, then 0x0D and 0x0A only if in_last was set.
REQ-019 SHALL frame each byte 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles.
REQ-020 SHALL go from STOP directly to START for the next byte of the same entry (no idle gap).
REQ-021 SHALL return to IDLE after the final byte's stop bit, holding tx high at least one cycle before the next entry's start bit.
REQ-022 SHALL register tx; tx low first appears in the cycle after the pop edge.
REQ-023 SHALL give latency: push on edge k into an empty, idle block -> pop on edge k+1 -> tx low from edge k+1.
REQ-024 SHALL pulse line_done high for exactly one cycle, on the edge leaving STOP of the 0x0A byte.
REQ-025 SHALL use a 16-bit bit-period counter, 3-bit bit index, 2-bit byte selector; pointers wrap modulo FIFO_DEPTH; count is width log2(FIFO_DEPTH)+1.
REQ-026 SHALL drive busy = (state != IDLE) || (count != 0).
REQ-027 SHALL handle a simultaneous push and pop on one edge with net count unchanged.

Reset
REQ-028 SHALL, on any edge with rst high, set state IDLE, tx=1, line_done=0, FIFO empty, all counters 0; in_ready=0 while rst high.
REQ-029 SHALL, on rst mid-frame, abort immediately: tx=1 from the next edge, holding register and FIFO discarded, no line_done.
REQ-030 SHALL assert in_ready=1, busy=0 in the first cycle after rst deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 SHALL cover: rst high 3 cycles -> tx=1, busy=0, in_ready=0; after release in_ready=1, tx=1.
REQ-032 SHALL cover: push lhs=0x41, rhs=0x61, last=0 -> tx low 1 cycle after push, frames 0x41 then 0x61 back to back, 80 cycles, then tx high, busy=0, no line_done.
REQ-033 SHALL cover: push 0x48/0x68 last=1 -> bytes 0x48,0x68,0x0D,0x0A over 160 cycles; exactly one line_done pulse at the final stop-bit end.
REQ-034 SHALL cover: in_valid held high with 6 distinct pairs -> exactly 5 accepted before in_ready falls; in_ready re-rises when the second entry pops; all 6 transmitted in order.
REQ-035 SHALL cover: rst asserted during DATA bit 3 of the first byte with 2 entries queued -> tx=1 next cycle, busy=0 after release, no line_done; a subsequent push of 0x5A/0x7A transmits cleanly.
REQ-036 SHALL cover: in_valid pulsed while in_ready=0 -> pair not stored; output stream unchanged.
